sdiv_ctrl: RTL and testbench

//  Signed fixed-point front/back end for the unsigned sequential divider (div).

---
 rtl/sdiv_ctrl.sv | 100 ++++++++++
 tb/tb_sdiv_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sdiv_ctrl.sv
// sdiv_ctrl: signed wrapper around an unsigned sequential divider (sign strip, launch, sign restore, overflow)
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid_i/in_ready_o, in_x_i/in_y_i          signed operand channel
//   out_valid_o/out_ready_i, out_q_o/out_r_o      signed result channel
//   out_dbz_o, out_ovf_o                          divide-by-zero / signed overflow flags
//   div_start_o, div_x_o, div_y_o                 launch pulse and magnitudes to the divider
//   div_busy_i, div_valid_i, div_dbz_i, div_ovf_i status from the divider
//   div_q_i, div_r_i                              unsigned quotient/remainder magnitudes
module sdiv_ctrl #(
    parameter int WIDTH = 8,
    parameter int FBITS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_x_i,
    input  logic [WIDTH-1:0] in_y_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_q_o,
    output logic [WIDTH-1:0] out_r_o,
    output logic             out_dbz_o,
    output logic             out_ovf_o,
    output logic             div_start_o,
    output logic [WIDTH-1:0] div_x_o,
    output logic [WIDTH-1:0] div_y_o,
    input  logic             div_busy_i,
    input  logic             div_valid_i,
    input  logic             div_dbz_i,
    input  logic             div_ovf_i,
    input  logic [WIDTH-1:0] div_q_i,
    input  logic [WIDTH-1:0] div_r_i
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};
    state_t           state_q;
    logic             sx_q, sy_q;
    logic             fire, done, neg, sgn_ovf, ovf_d, norm_d;
    logic [WIDTH-1:0] ax_d, ay_d, q_d, r_d;
    // The divider has no reset, so readiness also waits for it to go idle.
    assign in_ready_o = !rst && state_q == IDLE && !div_busy_i;
    assign fire       = in_valid_i && in_ready_o;
    assign done       = !div_busy_i && (div_valid_i || div_dbz_i || div_ovf_i);
    // Two's-complement negation also maps the most negative value onto 2^(WIDTH-1) unsigned.
    assign ax_d       = in_x_i[WIDTH-1] ? -in_x_i : in_x_i;
    assign ay_d       = in_y_i[WIDTH-1] ? -in_y_i : in_y_i;
    assign neg        = sx_q ^ sy_q;
    // A negative quotient may reach magnitude 2^(WIDTH-1); a positive one may not.
    assign sgn_ovf    = neg ? div_q_i > MIN_MAG : div_q_i >= MIN_MAG;
    assign ovf_d      = !div_dbz_i && (div_ovf_i || sgn_ovf);
    assign norm_d     = !div_dbz_i && !ovf_d;
    assign q_d        = neg ? -div_q_i : div_q_i;
    assign r_d        = sx_q ? -div_r_i : div_r_i;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            div_x_o     <= '0;
            div_y_o     <= '0;
            div_start_o <= 1'b0;
            out_valid_o <= 1'b0;
            out_q_o     <= '0;
            out_r_o     <= '0;
            out_dbz_o   <= 1'b0;
            out_ovf_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (fire) begin
                    sx_q        <= in_x_i[WIDTH-1];
                    sy_q        <= in_y_i[WIDTH-1];
                    div_x_o     <= ax_d;
                    div_y_o     <= ay_d;
                    div_start_o <= 1'b1;
                    state_q     <= LAUNCH;
                end
                LAUNCH: begin
                    div_start_o <= 1'b0;
                    state_q     <= WAIT;
                end
                WAIT: if (done) begin
                    out_dbz_o   <= div_dbz_i;
                    out_ovf_o   <= ovf_d;
                    out_q_o     <= norm_d ? q_d : '0;
                    out_r_o     <= norm_d ? r_d : '0;
                    out_valid_o <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: if (out_ready_i) begin
                    out_valid_o <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdiv_ctrl.sv
// tb_sdiv_ctrl: random and directed checks of sdiv_ctrl (FBITS=0 and FBITS=4) against an arithmetic reference
module tb_sdiv_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid [2];
    logic       in_ready [2];
    logic [7:0] in_x [2];
    logic [7:0] in_y [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_q [2];
    logic [7:0] out_r [2];
    logic       out_dbz [2];
    logic       out_ovf [2];
    logic       div_start [2];
    logic [7:0] div_x [2];
    logic [7:0] div_y [2];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int FB = 4 * g;
        localparam int IT = 8 + FB;
        logic        busy = 1'b0, vld = 1'b0, dbz = 1'b0, ovf = 1'b0;
        logic [7:0]  q = '0, r = '0, ay = '0;
        logic [31:0] xw = '0;
        int          cnt = 0;
        sdiv_ctrl #(.WIDTH(8), .FBITS(FB)) dut (
            .clk(clk), .rst(rst),
            .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]),
            .in_x_i(in_x[g]), .in_y_i(in_y[g]),
            .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]),
            .out_q_o(out_q[g]), .out_r_o(out_r[g]),
            .out_dbz_o(out_dbz[g]), .out_ovf_o(out_ovf[g]),
            .div_start_o(div_start[g]), .div_x_o(div_x[g]), .div_y_o(div_y[g]),
            .div_busy_i(busy), .div_valid_i(vld), .div_dbz_i(dbz), .div_ovf_i(ovf),
            .div_q_i(q), .div_r_i(r)
        );
        // Divider stand-in: dbz the cycle after start, overflow after WIDTH cycles, result after ITER cycles.
        always @(posedge clk) begin
            vld <= 1'b0;
            if (div_start[g]) begin
                xw   <= {24'd0, div_x[g]} << FB;
                ay   <= div_y[g];
                dbz  <= div_y[g] == 8'd0;
                ovf  <= 1'b0;
                busy <= div_y[g] != 8'd0;
                cnt  <= (div_y[g] != 8'd0 && ({24'd0, div_x[g]} << FB) / {24'd0, div_y[g]} >= 256) ? 8 : IT;
            end else if (busy) begin
                if (cnt == 1) begin
                    busy <= 1'b0;
                    if (xw / {24'd0, ay} >= 256) ovf <= 1'b1;
                    else begin
                        vld <= 1'b1;
                        q   <= 8'(xw / {24'd0, ay});
                        r   <= 8'(xw % {24'd0, ay});
                    end
                end else cnt <= cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mag(input logic [7:0] v);
        int vi = $signed(v);
        return 8'(vi < 0 ? -vi : vi);
    endfunction

    // Truncating signed division of x*2^fb by y, with the divider's own overflow and the signed-range limit.
    function automatic void model(input int fb, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] eq, output logic [7:0] er,
                                  output logic ed, output logic eo, output int lat);
        int xi = $signed(x);
        int yi = $signed(y);
        int xs = xi * (1 << fb);
        int qs, rs;
        eq = 8'd0; er = 8'd0; ed = 1'b0; eo = 1'b0; lat = 8 + fb + 3;
        if (yi == 0) begin
            ed = 1'b1; lat = 3;
        end else if ((xs < 0 ? -xs : xs) / (yi < 0 ? -yi : yi) >= 256) begin
            eo = 1'b1; lat = 8 + 3;
        end else begin
            qs = xs / yi;
            rs = xs % yi;
            if (qs > 127 || qs < -128) eo = 1'b1;
            else begin
                eq = 8'(qs); er = 8'(rs);
            end
        end
    endfunction

    task automatic run(input int k, input logic [7:0] x, input logic [7:0] y, input int hold);
        logic [7:0] eq, er;
        logic       ed, eo;
        int         el, c, starts;
        model(4 * k, x, y, eq, er, ed, eo, el);
        c = 0;
        while (!in_ready[k] && c < 50) begin @(posedge clk); #1; c++; end
        chk("in_ready_idle", 32'(in_ready[k]), 1);
        in_valid[k] = 1'b1; in_x[k] = x; in_y[k] = y;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        chk("div_x", div_x[k], mag(x));
        chk("div_y", div_y[k], mag(y));
        chk("in_ready_busy", 32'(in_ready[k]), 0);
        c = 1; starts = 0;
        while (!out_valid[k] && c < 100) begin
            starts += int'(div_start[k]);
            @(posedge clk); #1; c++;
        end
        chk("latency", c, el);
        chk("start_pulses", starts, 1);
        chk("q", out_q[k], eq);
        chk("r", out_r[k], er);
        chk("dbz", 32'(out_dbz[k]), 32'(ed));
        chk("ovf", 32'(out_ovf[k]), 32'(eo));
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid[k]), 1);
            chk("hold_q", out_q[k], eq);
            chk("hold_r", out_r[k], er);
            chk("hold_ready", 32'(in_ready[k]), 0);
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk("valid_clear", 32'(out_valid[k]), 0);
        chk("q_kept", out_q[k], eq);
    endtask

    initial begin
        int c;
        logic [7:0] x, y;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_x[i] = '0; in_y[i] = '0; out_ready[i] = 1'b0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", 32'(in_ready[i]), 0);
            chk("rst_valid", 32'(out_valid[i]), 0);
            chk("rst_q", out_q[i], 0);
            chk("rst_start", 32'(div_start[i]), 0);
            chk("rst_div_x", div_x[i], 0);
        end
        rst = 1'b0;
        run(0, 8'hF9, 8'h02, 0);
        run(0, 8'h07, 8'hFE, 0);
        run(0, 8'hF9, 8'hFE, 0);
        run(0, 8'h05, 8'h00, 1);
        run(0, 8'h80, 8'hFF, 0);
        run(0, 8'h80, 8'h01, 0);
        run(0, 8'h7F, 8'h01, 0);
        run(1, 8'hE8, 8'h08, 0);
        run(1, 8'h7F, 8'h01, 0);
        run(1, 8'h10, 8'h00, 0);
        run(0, 8'h64, 8'h07, 5);
        // Reset while waiting on the divider.
        in_valid[0] = 1'b1; in_x[0] = 8'h64; in_y[0] = 8'h03;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid[0]), 0);
        chk("mid_rst_q", out_q[0], 0);
        chk("mid_rst_ready", 32'(in_ready[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_ready", 32'(in_ready[0]), 0);
        c = 0;
        while (!in_ready[0] && c < 50) begin @(posedge clk); #1; c++; end
        chk("ready_after_busy", 32'(in_ready[0]), 1);
        chk("busy_low", 32'(u[0].busy), 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("late_valid_ignored", 32'(out_valid[0]), 0);
        end
        for (int i = 0; i < 60; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            case ($urandom_range(0, 5))
                0: y = 8'h00;
                1: x = 8'h80;
                2: y = 8'hFF;
                3: y = 8'($urandom_range(1, 3));
                default: ;
            endcase
            run(int'($urandom_range(0, 1)), x, y, int'($urandom_range(0, 3)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
